multi_zone_sprinkler: RTL and testbench

Parametrised N-zone irrigation sequencer. Generalises the two-valve watering FSM to NUM_ZONES valves with run-time zone skipping, an abort input and status outputs. On start it waters each enabled zone in ascending index order, with a dry pause between consecutive zones. It sits between the front-panel buttons and the valve driver outputs.

---
 rtl/multi_zone_sprinkler.sv | 148 ++++++++++++++
 tb/tb_multi_zone_sprinkler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_zone_sprinkler.sv
// multi_zone_sprinkler
//   N-zone irrigation sequencer. A start in IDLE latches skip_mask and waters
//   every unmasked zone in ascending order. Each zone stays open for WATER_TICKS
//   cycles, and a PAUSE_TICKS all-closed gap separates consecutive zones.
//   stop_button aborts the run from any busy state.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start_button  : start request, honoured only in IDLE
//   stop_button   : abort request, honoured while busy
//   skip_mask     : bit i=1 skips zone i (latched at start)
//   valve_open    : one-hot (or zero) valve drive
//   active_zone   : zone being watered, or next to be watered during PAUSE
//   busy          : high whenever not IDLE
//   cycle_done    : one-cycle pulse on normal completion
//
// All outputs decode registered state only, so no input reaches an output
// combinationally.
module multi_zone_sprinkler #(
    parameter int NUM_ZONES   = 4,
    parameter int ZONE_W      = 2,
    parameter int WATER_TICKS = 100,
    parameter int PAUSE_TICKS = 50,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_button,
    input  logic                 stop_button,
    input  logic [NUM_ZONES-1:0] skip_mask,
    output logic [NUM_ZONES-1:0] valve_open,
    output logic [ZONE_W-1:0]    active_zone,
    output logic                 busy,
    output logic                 cycle_done
);

    typedef enum logic [1:0] {IDLE, WATER, PAUSE} state_t;

    localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(WATER_TICKS - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [NUM_ZONES-1:0] mask_q,  mask_d;
    logic [ZONE_W-1:0]    zone_q,  zone_d;
    logic                 done_q,  done_d;

    // first_zone: lowest unmasked index of the incoming mask (used at start).
    // next_zone : lowest unmasked index above zone_q in the latched mask.
    // The loops run downward, so the last hit is the lowest matching index.
    logic [ZONE_W-1:0] first_zone, next_zone;
    logic              has_next;

    always_comb begin
        first_zone = '0;
        next_zone  = '0;
        has_next   = 1'b0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (!skip_mask[i])
                first_zone = ZONE_W'(i);
            if (!mask_q[i] && (i > int'(zone_q))) begin
                next_zone = ZONE_W'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            mask_q  <= '0;
            zone_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            mask_q  <= mask_d;
            zone_q  <= zone_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mask_d  = mask_q;
        zone_d  = zone_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // An all-ones mask would leave nothing to water, so the start is dropped.
                if (start_button && !stop_button && !(&skip_mask)) begin
                    state_d = WATER;
                    mask_d  = skip_mask;
                    zone_d  = first_zone;
                    timer_d = '0;
                end
            end
            WATER: begin
                if (stop_button) begin
                    state_d = IDLE;
                    zone_d  = '0;
                    timer_d = '0;
                end else if (timer_q == WATER_LAST) begin
                    timer_d = '0;
                    if (has_next) begin
                        state_d = PAUSE;
                        zone_d  = next_zone;
                    end else begin
                        state_d = IDLE;
                        zone_d  = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            PAUSE: begin
                if (stop_button) begin
                    state_d = IDLE;
                    zone_d  = '0;
                    timer_d = '0;
                end else if (timer_q == PAUSE_LAST) begin
                    state_d = WATER;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                zone_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    // Each valve decodes its own index against the registered zone.
    for (genvar g = 0; g < NUM_ZONES; g++) begin : g_valve
        assign valve_open[g] = (state_q == WATER) && (zone_q == ZONE_W'(g));
    end

    assign active_zone = zone_q;
    assign busy        = (state_q != IDLE);
    assign cycle_done  = done_q;

endmodule

// File: tb/tb_multi_zone_sprinkler.sv
module tb_multi_zone_sprinkler;
    localparam int NZ = 4;
    localparam int ZW = 2;
    localparam int WT = 4;
    localparam int PT = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_button = 1'b0;
    logic          stop_button = 1'b0;
    logic [NZ-1:0] skip_mask = '0;
    logic [NZ-1:0] valve_open;
    logic [ZW-1:0] active_zone;
    logic          busy;
    logic          cycle_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_zone_sprinkler #(
        .NUM_ZONES(NZ), .ZONE_W(ZW), .WATER_TICKS(WT), .PAUSE_TICKS(PT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start_button(start_button), .stop_button(stop_button),
        .skip_mask(skip_mask), .valve_open(valve_open), .active_zone(active_zone),
        .busy(busy), .cycle_done(cycle_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is a list of zones plus elapsed cycles since
    // start. The outputs are derived from that with plain arithmetic.
    bit m_busy = 0;
    bit m_done = 0;
    int m_t = 0;
    int m_n = 0;
    int m_list[NZ];

    always @(posedge clk) begin
        m_done = 0;
        if (rst) begin
            m_busy = 0;
            m_t = 0;
        end else if (m_busy) begin
            if (stop_button) m_busy = 0;
            else begin
                m_t++;
                if (m_t == m_n * WT + (m_n - 1) * PT) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (start_button && !stop_button && skip_mask != '1) begin
            m_n = 0;
            for (int i = 0; i < NZ; i++)
                if (!skip_mask[i]) begin
                    m_list[m_n] = i;
                    m_n++;
                end
            m_busy = 1;
            m_t = 0;
        end
    end

    logic [NZ-1:0] e_valve;
    int e_zone, e_seg, e_off;

    always @(negedge clk) begin
        e_valve = '0;
        e_zone = 0;
        if (m_busy) begin
            e_seg = m_t / (WT + PT);
            e_off = m_t % (WT + PT);
            if (e_off < WT) begin
                e_zone = m_list[e_seg];
                e_valve = NZ'(1) << e_zone;
            end else begin
                e_zone = m_list[e_seg + 1];
            end
            chk("active_zone", 32'(active_zone), 32'(e_zone));
        end
        chk("valve_open", 32'(valve_open), 32'(e_valve));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("cycle_done", 32'(cycle_done), 32'(m_done));
        chk("onehot", 32'($countones(valve_open) <= 1), 32'd1);
    end

    logic [NZ-1:0] trace[256];
    int nb;

    task automatic drive_start(input logic [NZ-1:0] m);
        @(negedge clk);
        skip_mask = m;
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
    endtask

    // Counts busy cycles from the current negedge, recording the valve trace.
    // The loop is capped at 200 cycles.
    task automatic count_busy(input bit toggle_mask, output int n);
        n = 0;
        while (busy && n < 200) begin
            trace[n] = valve_open;
            n++;
            if (toggle_mask) skip_mask = NZ'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valve", 32'(valve_open), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_zone", 32'(active_zone), 32'd0);
        chk("rst_done", 32'(cycle_done), 32'd0);

        // 1: full cycle
        drive_start(4'b0000);
        count_busy(1'b0, nb);
        chk("t1_busy_len", 32'(nb), 32'd22);
        chk("t1_done", 32'(cycle_done), 32'd1);
        chk("t1_tr0", 32'(trace[0]), 32'b0001);
        chk("t1_tr3", 32'(trace[3]), 32'b0001);
        chk("t1_tr4", 32'(trace[4]), 32'b0000);
        chk("t1_tr6", 32'(trace[6]), 32'b0010);
        chk("t1_tr12", 32'(trace[12]), 32'b0100);
        chk("t1_tr21", 32'(trace[21]), 32'b1000);
        @(negedge clk);
        chk("t1_done_once", 32'(cycle_done), 32'd0);

        // 2: skip mask, mask toggling mid-run
        drive_start(4'b1010);
        count_busy(1'b1, nb);
        chk("t2_busy_len", 32'(nb), 32'd10);
        chk("t2_tr6", 32'(trace[6]), 32'b0100);
        chk("t2_done", 32'(cycle_done), 32'd1);
        skip_mask = '0;

        // 3: abort during 2nd cycle of zone 1
        drive_start(4'b0000);
        repeat (7) @(negedge clk);
        chk("t3_pre_valve", 32'(valve_open), 32'b0010);
        stop_button = 1'b1;
        @(negedge clk);
        stop_button = 1'b0;
        chk("t3_valve", 32'(valve_open), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_zone", 32'(active_zone), 32'd0);
        chk("t3_done", 32'(cycle_done), 32'd0);
        drive_start(4'b0000);
        chk("t3_restart", 32'(valve_open), 32'b0001);
        wait_idle();

        // 4: all skipped
        drive_start(4'b1111);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_valve", 32'(valve_open), 32'd0);
        @(negedge clk);
        chk("t4_done", 32'(cycle_done), 32'd0);

        // 5: start held
        skip_mask = '0;
        start_button = 1'b1;
        @(negedge clk);
        count_busy(1'b0, nb);
        chk("t5_busy_len", 32'(nb), 32'd22);
        chk("t5_done", 32'(cycle_done), 32'd1);
        @(negedge clk);
        chk("t5_retrig_valve", 32'(valve_open), 32'b0001);
        chk("t5_retrig_busy", 32'(busy), 32'd1);
        start_button = 1'b0;
        wait_idle();

        // 6: reset in PAUSE before zone 2, then start+stop together
        drive_start(4'b0000);
        repeat (10) @(negedge clk);
        chk("t6_in_pause", 32'(valve_open), 32'd0);
        chk("t6_next_zone", 32'(active_zone), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_valve", 32'(valve_open), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_zone", 32'(active_zone), 32'd0);
        chk("t6_done", 32'(cycle_done), 32'd0);
        start_button = 1'b1;
        stop_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        stop_button = 1'b0;
        chk("t6_startstop", 32'(busy), 32'd0);

        // random phase, compared by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            start_button = ($urandom % 6) == 0;
            stop_button = ($urandom % 50) == 0;
            skip_mask = NZ'($urandom);
            rst = ($urandom % 300) == 0;
            @(negedge clk);
        end
        rst = 1'b0;
        start_button = 1'b0;
        stop_button = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
